// File: rtl/copy_fork_pkg.sv
// copy_fork_pkg: shared state encoding and delay-counter width helper for the copy-fork controller.
// Rev 1.0
`default_nettype none

package copy_fork_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FWD_DLY = 2'd1,
    SEND    = 2'd2,
    BWD_DLY = 2'd3
  } state_e;

  // Counter must hold the larger delay; never narrower than one bit.
  function automatic int cnt_w(input int fl, input int bl);
    int m;
    m = (fl > bl) ? fl : bl;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/copy_fork_dly_cnt.sv
// copy_fork_dly_cnt: loadable down-counter, last_o flags the final cycle of a delay window.
// Rev 1.0
`default_nettype none

module copy_fork_dly_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == W'(1));

endmodule

`default_nettype wire

// File: rtl/copy_fork_ctrl.sv
// copy_fork_ctrl: 1-to-N copy-fork sequencer with FL/BL delays; watchdog enabled by COPY_FORK_STALL_EN.
// Rev 1.0
`default_nettype none

module copy_fork_ctrl
  import copy_fork_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N         = 3,
  parameter int FL        = 2,
  parameter int BL        = 8,
  parameter int STALL_LIM = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [N-1:0]     out_en,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             stall
);

  localparam int            CW   = cnt_w(FL, BL);
  localparam logic [CW-1:0] FL_C = CW'(FL);
  localparam logic [CW-1:0] BL_C = CW'(BL);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [N-1:0]     done_q, done_d;
  logic [N-1:0]     hs;
  logic             all_done;
  logic             cnt_load, cnt_dec, cnt_last;
  logic [CW-1:0]    cnt_val;

  assign in_ready  = rst_n && (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == SEND) ? (mask_q & ~done_q) : '0;
  assign out_data  = data_q;
  assign hs        = out_valid & out_ready;
  // Handshakes landing this cycle count toward completion.
  assign all_done  = &((done_q | hs) | ~mask_q);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mask_d   = mask_q;
    done_d   = done_q;
    cnt_load = 1'b0;
    cnt_val  = FL_C;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d = in_data;
          mask_d = out_en;
          if (|out_en) begin
            if (FL == 0) begin
              state_d = SEND;
            end else begin
              state_d  = FWD_DLY;
              cnt_load = 1'b1;
              cnt_val  = FL_C;
            end
          end else if (BL != 0) begin
            state_d  = BWD_DLY;
            cnt_load = 1'b1;
            cnt_val  = BL_C;
          end
        end
      end
      FWD_DLY: begin
        cnt_dec = 1'b1;
        if (cnt_last) state_d = SEND;
      end
      SEND: begin
        done_d = done_q | hs;
        if (all_done) begin
          done_d = '0;
          if (BL == 0) begin
            state_d = IDLE;
          end else begin
            state_d  = BWD_DLY;
            cnt_load = 1'b1;
            cnt_val  = BL_C;
          end
        end
      end
      BWD_DLY: begin
        cnt_dec = 1'b1;
        if (cnt_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
    end
  end

  copy_fork_dly_cnt #(
    .W (CW)
  ) u_dly_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .val_i  (cnt_val),
    .dec_i  (cnt_dec),
    .last_o (cnt_last)
  );

`ifdef COPY_FORK_STALL_EN
  localparam int            SW    = ($clog2(STALL_LIM + 1) > 7) ? $clog2(STALL_LIM + 1) : 7;
  localparam logic [SW-1:0] LIM_C = SW'(STALL_LIM);

  logic [SW-1:0] wcnt_q, wcnt_d;
  logic          stall_q, stall_d;

  // Saturating idle-cycle count; the flag latches until SEND is left.
  always_comb begin
    wcnt_d  = '0;
    stall_d = 1'b0;
    if ((state_q == SEND) && (state_d == SEND)) begin
      if (|hs) begin
        wcnt_d = '0;
      end else if (wcnt_q != LIM_C) begin
        wcnt_d = wcnt_q + 1'b1;
      end else begin
        wcnt_d = wcnt_q;
      end
      stall_d = stall_q | (wcnt_d == LIM_C);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall = stall_q;
`else
  assign stall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_copy_fork_ctrl.sv
// tb_copy_fork_ctrl: scoreboard bench for copy_fork_ctrl (FL=2/BL=8 instance and FL=BL=0 instance).
// Rev 1.0
`default_nettype none

module tb_copy_fork_ctrl;

`ifdef COPY_FORK_STALL_EN
  localparam logic STALL_ON = 1'b1;
`else
  localparam logic STALL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_in_valid, a_in_ready, a_busy, a_stall;
  logic [7:0] a_in_data, a_out_data;
  logic [2:0] a_out_en, a_out_valid, a_out_ready;
  logic       b_in_valid, b_in_ready, b_busy, b_stall;
  logic [7:0] b_in_data, b_out_data;
  logic [2:0] b_out_en, b_out_valid, b_out_ready;

  int total = 0;
  int bad   = 0;

  logic [7:0] qa[3][$];
  logic [7:0] qb[3][$];

  copy_fork_ctrl #(.WIDTH(8), .N(3), .FL(2), .BL(8), .STALL_LIM(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_en(a_out_en), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .busy(a_busy), .stall(a_stall));

  copy_fork_ctrl #(.WIDTH(8), .N(3), .FL(0), .BL(0), .STALL_LIM(16)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_en(b_out_en), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy), .stall(b_stall));

  // Scoreboard: push on accepted token per enabled branch, pop on each branch handshake.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin qa[i].delete(); qb[i].delete(); end
    end else begin
      if (a_in_valid && a_in_ready)
        for (int i = 0; i < 3; i++) if (a_out_en[i]) qa[i].push_back(a_in_data);
      if (b_in_valid && b_in_ready)
        for (int i = 0; i < 3; i++) if (b_out_en[i]) qb[i].push_back(b_in_data);
      for (int i = 0; i < 3; i++) begin
        if (a_out_valid[i]) begin
          if (qa[i].size() == 0) begin
            total++; bad++;
            $display("FAIL a_spurious br%0d: out_valid=1 want 0 (no token owed)", i);
          end else if (a_out_ready[i]) begin
            e = qa[i].pop_front();
            total++;
            if (a_out_data !== e) begin
              bad++; $display("FAIL a_data br%0d: got %h want %h", i, a_out_data, e);
            end
          end
        end
        if (b_out_valid[i]) begin
          if (qb[i].size() == 0) begin
            total++; bad++;
            $display("FAIL b_spurious br%0d: out_valid=1 want 0 (no token owed)", i);
          end else if (b_out_ready[i]) begin
            e = qb[i].pop_front();
            total++;
            if (b_out_data !== e) begin
              bad++; $display("FAIL b_data br%0d: got %h want %h", i, b_out_data, e);
            end
          end
        end
      end
    end
  end

  // Offer a token on DUT A; returns just after the accepting edge.
  task automatic send_a(input logic [7:0] d, input logic [2:0] en);
    int n = 0;
    a_in_valid = 1'b1; a_in_data = d; a_out_en = en;
    @(negedge clk);
    while (!a_in_ready && n < 300) begin @(negedge clk); n++; end
    total++;
    if (!a_in_ready) begin bad++; $display("FAIL send_a: in_ready got 0 want 1 (timeout)"); end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  // Cycle index (after accept) of first out_valid and of in_ready return; -1 if unseen.
  task automatic watch_a(output int tv, output int tr, output logic [2:0] ov);
    tv = -1; tr = -1; ov = '0;
    for (int k = 0; k < 40 && tr < 0; k++) begin
      @(negedge clk);
      if (tv < 0 && a_out_valid != 3'b000) tv = k;
      if (a_in_ready) tr = k;
      ov = ov | a_out_valid;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_out_en = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_out_en = 0; b_out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", a_in_ready); end
    total++; if (a_out_valid !== 3'b000) begin bad++; $display("FAIL rst_out_valid: got %b want 000", a_out_valid); end
    total++; if (a_out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data: got %h want 00", a_out_data); end
    total++; if ({a_busy, a_stall, b_busy} !== 3'b000) begin bad++; $display("FAIL rst_busy_stall: got %b want 000", {a_busy, a_stall, b_busy}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({a_in_ready, b_in_ready} !== 2'b11) begin bad++; $display("FAIL rst_release_ready: got %b want 11", {a_in_ready, b_in_ready}); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int tv, tr; logic [2:0] ov;
    a_out_ready = 3'b111;
    send_a(8'h5A, 3'b111);
    watch_a(tv, tr, ov);
    total++; if (tv !== 2) begin bad++; $display("FAIL basic_fwd_latency: got %0d want 2", tv); end
    total++; if (tr !== 11) begin bad++; $display("FAIL basic_in_ready_return: got %0d want 11", tr); end
    total++; if (ov !== 3'b111) begin bad++; $display("FAIL basic_branches: got %b want 111", ov); end
  endtask

  task automatic test_stagger();
    int n = 0;
    a_out_ready = 3'b000;
    send_a(8'hC3, 3'b111);
    @(posedge clk); #1; @(posedge clk); #1;
    for (int j = 0; j < 7; j++) begin
      a_out_ready = {j >= 3, j >= 6, 1'b1};
      @(negedge clk);
      total++;
      if (a_out_valid !== {j <= 3, 1'b1, j == 0}) begin
        bad++; $display("FAIL stagger_valid j=%0d: got %b want %b", j, a_out_valid, {j <= 3, 1'b1, j == 0});
      end
      total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL stagger_in_ready j=%0d: got 1 want 0", j); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    while (!a_in_ready && n < 40) begin @(negedge clk); n++; end
    total++; if (n !== 8) begin bad++; $display("FAIL stagger_bwd: got %0d want 8", n); end
    @(posedge clk); #1;
    a_out_ready = 3'b111;
  endtask

  task automatic test_mask();
    int tv, tr; logic [2:0] ov;
    a_out_ready = 3'b111;
    send_a(8'h96, 3'b101);
    a_out_en = 3'b111;
    watch_a(tv, tr, ov);
    total++; if (ov !== 3'b101) begin bad++; $display("FAIL mask_branches: got %b want 101", ov); end
    total++; if (tr !== 11) begin bad++; $display("FAIL mask_in_ready_return: got %0d want 11", tr); end
    send_a(8'hE1, 3'b000);
    watch_a(tv, tr, ov);
    total++; if (ov !== 3'b000) begin bad++; $display("FAIL drop_valid: got %b want 000", ov); end
    total++; if (tr !== 8) begin bad++; $display("FAIL drop_in_ready_return: got %0d want 8", tr); end
  endtask

  task automatic test_back_to_back();
    int acc = 0, last = -1, cyc = 0;
    logic will;
    b_out_ready = 3'b111; b_out_en = 3'b111;
    b_in_valid = 1'b1; b_in_data = 8'd0;
    while (acc < 10 && cyc < 100) begin
      @(negedge clk);
      will = b_in_ready;
      @(posedge clk); #1;
      cyc++;
      if (will) begin
        if (last >= 0) begin
          total++; if (cyc - last !== 2) begin bad++; $display("FAIL b2b_spacing tok%0d: got %0d want 2", acc, cyc - last); end
        end
        last = cyc; acc++; b_in_data = acc[7:0];
      end
    end
    b_in_valid = 1'b0;
    total++; if (acc !== 10) begin bad++; $display("FAIL b2b_count: got %0d want 10", acc); end
    repeat (4) @(posedge clk); #1;
    total++;
    if (qb[0].size() + qb[1].size() + qb[2].size() != 0) begin
      bad++; $display("FAIL b2b_drain: got %0d outstanding want 0", qb[0].size() + qb[1].size() + qb[2].size());
    end
  endtask

  task automatic test_reset_mid();
    int tv, tr; logic [2:0] ov;
    a_out_ready = 3'b101;
    send_a(8'h77, 3'b111);
    @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
    @(negedge clk);
    total++; if (a_out_valid !== 3'b010) begin bad++; $display("FAIL rmid_pending: got %b want 010", a_out_valid); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (a_out_valid !== 3'b000) begin bad++; $display("FAIL rmid_valid: got %b want 000", a_out_valid); end
    total++; if ({a_busy, a_in_ready} !== 2'b00) begin bad++; $display("FAIL rmid_busy_ready: got %b want 00", {a_busy, a_in_ready}); end
    total++; if (a_out_data !== 8'h00) begin bad++; $display("FAIL rmid_data: got %h want 00", a_out_data); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_out_ready = 3'b111;
    send_a(8'h33, 3'b111);
    watch_a(tv, tr, ov);
    total++; if (tv !== 2 || tr !== 11) begin bad++; $display("FAIL rmid_new_token: got tv=%0d tr=%0d want tv=2 tr=11", tv, tr); end
  endtask

  task automatic test_stall();
    int n = 0;
    a_out_ready = 3'b011;
    send_a(8'h44, 3'b111);
    @(posedge clk); #1; @(posedge clk); #1;
    for (int j = 0; j < 18; j++) begin
      @(negedge clk);
      if (j == 16 || j == 17) begin
        total++;
        if (a_stall !== ((j == 17) ? STALL_ON : 1'b0)) begin
          bad++; $display("FAIL stall_j%0d: got %b want %b", j, a_stall, (j == 17) ? STALL_ON : 1'b0);
        end
      end
      @(posedge clk); #1;
    end
    a_out_ready = 3'b111;
    @(negedge clk);
    total++; if (a_stall !== STALL_ON) begin bad++; $display("FAIL stall_hold: got %b want %b", a_stall, STALL_ON); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (a_stall !== 1'b0) begin bad++; $display("FAIL stall_clear: got %b want 0", a_stall); end
    while (!a_in_ready && n < 40) begin @(negedge clk); n++; end
    total++; if (!a_in_ready) begin bad++; $display("FAIL stall_recover: in_ready got 0 want 1"); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stagger();
    test_mask();
    test_back_to_back();
    test_reset_mid();
    test_stall();
    repeat (2) @(posedge clk); #1;
    total++;
    if (qa[0].size() + qa[1].size() + qa[2].size() != 0) begin
      bad++; $display("FAIL a_drain: got %0d outstanding want 0", qa[0].size() + qa[1].size() + qa[2].size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
